// File: rtl/moving_average_filter.sv
// Running-sum boxcar filter: samples on every toggle of a selected NCO phase bit,
// averages over a runtime power-of-two window using a circular sample buffer.
module moving_average_filter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_LOG2 = 6,
    parameter int unsigned PHASE_W  = 32,
    parameter int unsigned SEL_W    = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [PHASE_W-1:0]                 phase,
    input  logic [SEL_W-1:0]                   sample_rate,
    input  logic [$clog2(MAX_LOG2+1)-1:0]      window_log2,
    input  logic                               clear,
    input  logic signed [DATA_W-1:0]           signal,
    output logic signed [DATA_W-1:0]           filtered,
    output logic                               valid,
    output logic                               filled
);

    localparam int unsigned WIN_W = $clog2(MAX_LOG2 + 1);
    localparam int unsigned DEPTH = 2 ** MAX_LOG2;
    localparam int unsigned SUM_W = DATA_W + MAX_LOG2;
    localparam int unsigned CNT_W = MAX_LOG2 + 1;
    localparam int unsigned PTR_W = MAX_LOG2;

    logic                     prev_bit_q, prev_bit_d;
    logic [WIN_W-1:0]         win_q, win_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic                     acc_q, acc_d;
    logic signed [DATA_W-1:0] filtered_d;
    logic                     valid_d;
    logic                     filled_d;

    logic signed [DATA_W-1:0] sample_mem [DEPTH];

    logic                     sel_bit_c;
    logic                     tick_c;
    logic [WIN_W-1:0]         win_c;
    logic                     win_chg_c;
    logic [CNT_W-1:0]         win_len_c;
    logic [PTR_W-1:0]         rd_addr_c;
    logic signed [DATA_W-1:0] oldest_c;
    logic [CNT_W-1:0]         count_inc_c;
    logic signed [SUM_W-1:0]  sum_add_c;
    logic                     wr_en_c;

    // Selected phase bit; indices beyond the phase width read as zero.
    always_comb begin
        sel_bit_c = 1'b0;
        for (int i = 0; i < int'(PHASE_W); i++) begin
            if (sample_rate == SEL_W'(i)) begin
                sel_bit_c = phase[i];
            end
        end
    end

    assign tick_c    = sel_bit_c != prev_bit_q;
    assign win_c     = (32'(window_log2) > MAX_LOG2) ? WIN_W'(MAX_LOG2) : window_log2;
    assign win_chg_c = win_c != win_q;

    // Oldest sample leaves the window only once the window is full; at the maximum
    // window the read address equals the write address and returns the pre-write value.
    assign win_len_c   = CNT_W'(1) << win_q;
    assign rd_addr_c   = wr_ptr_q - PTR_W'(win_len_c);
    assign oldest_c    = (count_q == win_len_c) ? sample_mem[rd_addr_c] : '0;
    assign count_inc_c = (count_q == win_len_c) ? count_q : count_q + CNT_W'(1);
    assign sum_add_c   = sum_q + SUM_W'(signal) - SUM_W'(oldest_c);

    always_comb begin
        prev_bit_d = sel_bit_c;
        win_d      = win_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        sum_d      = sum_q;
        acc_d      = 1'b0;
        filled_d   = filled;
        valid_d    = acc_q;
        filtered_d = acc_q ? DATA_W'(sum_q >>> win_q) : filtered;
        wr_en_c    = 1'b0;

        if (clear || win_chg_c) begin
            // Flush history and drop any tick or pending output on this edge.
            sum_d      = '0;
            count_d    = '0;
            filled_d   = 1'b0;
            valid_d    = 1'b0;
            filtered_d = filtered;
            win_d      = win_c;
        end else if (tick_c) begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            sum_d    = sum_add_c;
            count_d  = count_inc_c;
            acc_d    = 1'b1;
            if (count_inc_c == win_len_c) begin
                filled_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_bit_q <= 1'b0;
            win_q      <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            sum_q      <= '0;
            acc_q      <= 1'b0;
            filtered   <= '0;
            valid      <= 1'b0;
            filled     <= 1'b0;
        end else begin
            prev_bit_q <= prev_bit_d;
            win_q      <= win_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            acc_q      <= acc_d;
            filtered   <= filtered_d;
            valid      <= valid_d;
            filled     <= filled_d;
        end
    end

    // Sample storage needs no reset; the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            sample_mem[wr_ptr_q] <= signal;
        end
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter: step, full scale, truncation,
// flush on window change/clear, tick detection and asynchronous reset.
module tb_moving_average_filter;

    logic               clk;
    logic               reset;
    logic [31:0]        phase;
    logic [4:0]         sample_rate;
    logic [2:0]         window_log2;
    logic               clear;
    logic signed [15:0] signal;
    logic signed [15:0] filtered;
    logic               valid;
    logic               filled;

    int tests;
    int fails;

    moving_average_filter #(
        .DATA_W(16), .MAX_LOG2(6), .PHASE_W(32), .SEL_W(5)
    ) dut (
        .clk(clk), .reset(reset), .phase(phase), .sample_rate(sample_rate),
        .window_log2(window_log2), .clear(clear), .signal(signal),
        .filtered(filtered), .valid(valid), .filled(filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One tick on phase[0] (sample_rate=0), then return just after the output edge.
    task automatic send(input logic [15:0] v);
        signal   = v;
        phase[0] = ~phase[0];
        step_cycles(2);
    endtask

    task automatic test_reset;
        tests++;
        if (filtered !== 16'h0000 || valid !== 1'b0 || filled !== 1'b0) begin
            $display("FAIL reset_state: filtered=%h valid=%b filled=%b, want 0000/0/0",
                     filtered, valid, filled);
            fails++;
        end
        reset = 1'b0;
        step_cycles(3);
    endtask

    task automatic test_step;
        logic [15:0] exp;
        for (int i = 0; i < 64; i++) begin
            send(16'h0400);
            exp = 16'(16 * (i + 1));
            tests++;
            if (filtered !== exp || valid !== 1'b1 || filled !== (i == 63)) begin
                $display("FAIL step[%0d]: filtered=%h valid=%b filled=%b, want %h/1/%b",
                         i, filtered, valid, filled, exp, (i == 63));
                fails++;
            end
        end
        step_cycles(1);
        tests++;
        if (valid !== 1'b0) begin
            $display("FAIL step_valid_pulse: valid=%b, want 0", valid);
            fails++;
        end
    endtask

    task automatic test_fullscale;
        for (int i = 0; i < 32; i++) send(16'h7FFF);
        tests++;
        if (filtered !== 16'h41FF) begin
            $display("FAIL fullscale_mix: filtered=%h, want 41ff", filtered);
            fails++;
        end
        for (int i = 0; i < 32; i++) send(16'h7FFF);
        tests++;
        if (filtered !== 16'h7FFF) begin
            $display("FAIL fullscale_pos: filtered=%h, want 7fff", filtered);
            fails++;
        end
        for (int i = 0; i < 32; i++) send(16'h8000);
        tests++;
        if (filtered !== 16'hFFFF) begin
            $display("FAIL fullscale_half: filtered=%h, want ffff", filtered);
            fails++;
        end
        for (int i = 0; i < 32; i++) send(16'h8000);
        tests++;
        if (filtered !== 16'h8000) begin
            $display("FAIL fullscale_neg: filtered=%h, want 8000", filtered);
            fails++;
        end
    endtask

    task automatic test_neg_trunc;
        window_log2 = 3'd1;
        step_cycles(2);
        send(16'hFFFF);
        tests++;
        if (filtered !== 16'hFFFF || filled !== 1'b0) begin
            $display("FAIL trunc_1: filtered=%h filled=%b, want ffff/0", filtered, filled);
            fails++;
        end
        send(16'h0000);
        tests++;
        if (filtered !== 16'hFFFF || filled !== 1'b1) begin
            $display("FAIL trunc_2: filtered=%h filled=%b, want ffff/1", filtered, filled);
            fails++;
        end
        send(16'h0000);
        tests++;
        if (filtered !== 16'h0000) begin
            $display("FAIL trunc_3: filtered=%h, want 0000", filtered);
            fails++;
        end
    endtask

    task automatic test_window_change;
        logic [15:0] exp;
        window_log2 = 3'd6;
        step_cycles(2);
        for (int i = 0; i < 64; i++) send(16'h0100);
        tests++;
        if (filtered !== 16'h0100 || filled !== 1'b1) begin
            $display("FAIL wchg_prefill: filtered=%h filled=%b, want 0100/1", filtered, filled);
            fails++;
        end
        // Window change lands on the same edge as a tick.
        window_log2 = 3'd2;
        signal      = 16'h0200;
        phase[0]    = ~phase[0];
        step_cycles(1);
        tests++;
        if (filled !== 1'b0) begin
            $display("FAIL wchg_flush: filled=%b, want 0", filled);
            fails++;
        end
        step_cycles(1);
        tests++;
        if (valid !== 1'b0) begin
            $display("FAIL wchg_discard: valid=%b, want 0", valid);
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            send(16'h0200);
            exp = 16'(16'h0080 * (i + 1));
            tests++;
            if (filtered !== exp || valid !== 1'b1 || filled !== (i == 3)) begin
                $display("FAIL wchg_ramp[%0d]: filtered=%h valid=%b filled=%b, want %h/1/%b",
                         i, filtered, valid, filled, exp, (i == 3));
                fails++;
            end
        end
    endtask

    task automatic test_clear;
        logic [15:0] exp;
        clear    = 1'b1;
        signal   = 16'h0400;
        phase[0] = ~phase[0];
        step_cycles(1);
        clear = 1'b0;
        tests++;
        if (filled !== 1'b0) begin
            $display("FAIL clear_flush: filled=%b, want 0", filled);
            fails++;
        end
        step_cycles(1);
        tests++;
        if (valid !== 1'b0) begin
            $display("FAIL clear_discard: valid=%b, want 0", valid);
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            send(16'h0200);
            exp = 16'(16'h0080 * (i + 1));
            tests++;
            if (filtered !== exp || filled !== (i == 3)) begin
                $display("FAIL clear_ramp[%0d]: filtered=%h filled=%b, want %h/%b",
                         i, filtered, filled, exp, (i == 3));
                fails++;
            end
        end
    endtask

    task automatic test_tick_detect;
        int pulses;
        int first;
        logic [15:0] prev_sig;
        window_log2 = 3'd0;
        sample_rate = 5'd3;
        phase       = 32'd0;
        signal      = 16'h1234;
        step_cycles(3);
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= 66; i++) begin
            phase = 32'(i);
            step_cycles(1);
            if (valid === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        tests++;
        if (pulses != 8 || first != 9) begin
            $display("FAIL tick_bit3: pulses=%0d first=%0d, want 8/9", pulses, first);
            fails++;
        end
        tests++;
        if (filtered !== 16'h1234) begin
            $display("FAIL passthrough: filtered=%h, want 1234", filtered);
            fails++;
        end
        // Every-cycle ticks with win=0: output follows input one tick later.
        sample_rate = 5'd0;
        step_cycles(3);
        prev_sig = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            signal = 16'(i * 37 + 5);
            phase  = phase + 32'd1;
            step_cycles(1);
            if (i > 0) begin
                tests++;
                if (valid !== 1'b1 || filtered !== prev_sig) begin
                    $display("FAIL tick_every[%0d]: filtered=%h valid=%b, want %h/1",
                             i, filtered, valid, prev_sig);
                    fails++;
                end
            end
            prev_sig = signal;
        end
        step_cycles(2);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step_cycles(1);
            if (valid === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            $display("FAIL static_phase: pulses=%0d, want 0", pulses);
            fails++;
        end
    endtask

    task automatic test_reset_mid;
        window_log2 = 3'd2;
        step_cycles(2);
        for (int i = 0; i < 4; i++) send(16'h0400);
        tests++;
        if (filtered !== 16'h0400 || filled !== 1'b1) begin
            $display("FAIL rst_prefill: filtered=%h filled=%b, want 0400/1", filtered, filled);
            fails++;
        end
        signal   = 16'h0400;
        phase[0] = ~phase[0];
        step_cycles(1);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (filtered !== 16'h0000 || valid !== 1'b0 || filled !== 1'b0) begin
            $display("FAIL rst_async: filtered=%h valid=%b filled=%b, want 0000/0/0",
                     filtered, valid, filled);
            fails++;
        end
        step_cycles(2);
        reset = 1'b0;
        step_cycles(3);
        send(16'h0400);
        tests++;
        if (filtered !== 16'h0100 || valid !== 1'b1) begin
            $display("FAIL rst_first_tick: filtered=%h valid=%b, want 0100/1", filtered, valid);
            fails++;
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        phase       = 32'd0;
        sample_rate = 5'd0;
        window_log2 = 3'd6;
        clear       = 1'b0;
        signal      = 16'sd0;
        #12;
        test_reset;
        test_step;
        test_fullscale;
        test_neg_trunc;
        test_window_change;
        test_clear;
        test_tick_detect;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/moving_average_filter.md
Name: moving_average_filter

Overview:
- Parametrised running-sum moving-average (boxcar) low-pass filter for the demodulation path; successor to the fixed 64-tap block averager.
- Samples signed input on every toggle of a selected phase-accumulator bit.
- Window length is runtime-selectable as a power of two up to 2^MAX_LOG2.
- Uses add-newest/subtract-oldest accumulation over a circular buffer instead of a full adder tree, and adds reset, clear, fill tracking and a valid strobe.

Parameters:
- DATA_W, 16, signed sample width of signal and filtered.
- MAX_LOG2, 6, log2 of buffer depth; maximum window is 2^MAX_LOG2 samples.
- PHASE_W, 32, width of phase input.
- SEL_W, 5, width of sample_rate; must satisfy 2^SEL_W >= PHASE_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- phase  input  PHASE_W  current phase of centre-frequency NCO
- sample_rate  input  SEL_W  index of phase bit whose toggles define sample ticks
- window_log2  input  clog2(MAX_LOG2+1)  requested window = 2^window_log2 samples
- clear  input  1  synchronous flush of filter history
- signal  input  DATA_W  signed input amplitude
- filtered  output  DATA_W  signed windowed mean
- valid  output  1  one-cycle pulse when filtered updates
- filled  output  1  high once window holds 2^win real samples since last flush

Behaviour:
- Reset (async): prev_bit=0, sum=0, count=0, wr_ptr=0, win=0, filtered=0, valid=0, filled=0. Buffer contents are not reset; count gating makes them irrelevant.
- Sample tick is phase[sample_rate] != prev_bit, evaluated each cycle. prev_bit <= phase[sample_rate] every cycle. Both rising and falling toggles are ticks.
- If sample_rate >= PHASE_W, the selected bit reads as 0, so no ticks occur.
- Effective win = min(window_log2, MAX_LOG2).
- Each cycle, win differing from the registered active window counts as a window change.
- Priority per edge: clear > window change > tick.
- clear or window change:
  - sum<=0, count<=0, filled<=0, valid<=0.
  - The active window loads win.
  - Any coincident tick sample is discarded.
  - wr_ptr is unchanged.
- Tick edge (accumulation edge):
  - buf[wr_ptr] <= sign-extended signal; wr_ptr <= wr_ptr+1, mod 2^MAX_LOG2.
  - oldest = buf[wr_ptr - 2^win], mod depth, if count == 2^win, else 0.
  - sum <= sum + signal - oldest.
  - count <= min(count+1, 2^win).
  - When count reaches 2^win, filled <= 1.
- Edge after accumulation:
  - filtered <= (sum >>> win)[DATA_W-1:0], an arithmetic shift truncating toward minus infinity.
  - valid <= 1 for exactly one cycle.
  - Latency: tick detected at edge k, filtered/valid at edge k+1.
- Before filled, the output is the zero-padded mean: partial sum divided by the full window.
- sum width is DATA_W+MAX_LOG2, signed, so it cannot overflow at any window. The truncated result always lies within the input range.
- win=0 gives a one-tap passthrough: filtered = signal with one-tick latency, and filled is set after the first sample.
- Ticks arriving on consecutive cycles, e.g. sample_rate=0 with phase[0] toggling every clk, are each accepted; throughput is one sample per cycle.
- Buffer read and write use the same address only when win=MAX_LOG2 and the window is full. In that case the read returns the pre-write (old) value, as required for correct subtraction.
- Reset asserted mid-operation takes effect immediately. After release, the first output requires a fresh tick.

Test Plan:
- Step response:
  - Stimulus: window_log2=6; 64 ticks of signal=0x0400.
  - Required: filtered ramps by 0x0010 per tick, 0x0010 through 0x0400. filled rises on tick 64. valid pulses once per tick, one cycle after each accumulation.
- Full-scale bound:
  - Stimulus: 64 ticks at 0x7FFF, then 64 ticks at 0x8000.
  - Required: filtered = 0x7FFF when full, then reaches 0x8000 with no wrap.
- Negative truncation and steady state:
  - Stimulus: window_log2=1; samples -1, 0, 0.
  - Required: filtered = 0xFFFF, 0xFFFF (sum -1 >>> 1), then 0x0000, the last after the -1 is subtracted out.
- Window change and clear:
  - Stimulus: filled window at 0x0100; change window_log2 6->2 coincident with a tick; then 4 ticks of 0x0200.
  - Required: tick discarded, sum cleared, filled=0; outputs 0x0080, 0x0100, 0x0180, 0x0200; filled after the 4th tick.
  - Stimulus: repeat with clear.
  - Required: same flush behaviour.
- Tick detection:
  - Stimulus: sample_rate=3; phase incremented by 1 each cycle.
  - Required: one tick per 8 cycles, on both edges of bit 3.
  - Stimulus: sample_rate=0.
  - Required: a tick every cycle.
  - Stimulus: static phase.
  - Required: valid never asserts.
- Reset mid-run:
  - Stimulus: assert reset asynchronously between clock edges during accumulation.
  - Required: filtered=0, valid=0, filled=0 immediately. The next tick after release yields signal>>>win.
